sram_bist_master: RTL and testbench
===================================

# sram_bist_master

Hardware bus initiator for the bridge-style SRAM bus (address / bus_enable / byte_enable / rw / write_data, answered by acknowledge / read_data). On a start pulse it fills a word region with an LFSR pattern, reads the region back and compares each word. It reports pass/fail, an error count and the first failing address. It sits in place of, or muxed with, the Nios bridge in front of the SRAM controller, for board bring-up and memory self-test.

## Interface
- ADDR_W, 19: byte-address width of the bus.
- DATA_W, 16: data width. Fixed at 16; byte_enable is 2 bits.
- One clock; reset is asynchronous and active-low.
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse. Ignored while busy.
- base_addr  in  18  first word address, sampled on start.
- word_count  in  18  number of words to test, sampled on start; 0 is allowed.
- seed  in  16  LFSR seed, sampled on start. A value of 0 is replaced by 16'hACE1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  sticky; set on completion, cleared by the next accepted start.
- pass  out  1  valid while done=1; 1 when error_count==0.
- error_count  out  16  number of mismatching words, saturating at 16'hFFFF.
- first_fail_addr  out  18  word address of the first mismatch; 0 if there is none.
- address  out  ADDR_W  byte address = {word_addr, 1'b0}.
- bus_enable  out  1  request, held until acknowledge.
- byte_enable  out  2  always 2'b11.
- rw  out  1  1 = read, 0 = write.
- write_data  out  16  write data.
- acknowledge  in  1  responder completion, one-cycle pulse.
- read_data  in  16  read data, valid in the acknowledge cycle.

## Operation
- States and transitions:
  - IDLE: on start with word_count≠0 → WR_REQ. On start with word_count=0 → DONE with pass=1.
  - WR_REQ: drives bus_enable=1, rw=0, address, write_data=lfsr → WR_WAIT.
  - WR_WAIT: on acknowledge, advance the index and the LFSR. If the last word was written, reload the LFSR from seed, reset the index and go → RD_REQ; otherwise → WR_REQ.
  - RD_REQ: drives bus_enable=1, rw=1 → RD_WAIT.
  - RD_WAIT: on acknowledge, register read_data → CHECK.
  - CHECK: on a mismatch against lfsr, increment error_count (saturating) and capture first_fail_addr if it is the first error. Advance the LFSR and index, then → RD_REQ, or → DONE after the last word.
  - DONE: done=1. The next start → WR_REQ or DONE, with the counters cleared.
- LFSR step: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. Word k of a pass uses the seed stepped k times.
- Word address = base_addr + index, modulo 2^18 (wraps silently).
- Reset values: all outputs 0, state IDLE, LFSR = 16'hACE1.
- Reset mid-operation: bus_enable drops asynchronously and no pending acknowledge is consumed afterward. The responder must tolerate an abandoned request.

## Timing
- bus_enable rises 1 cycle after entry to *_REQ. address, rw, write_data and byte_enable are registered and stable for as long as bus_enable=1.
- Acknowledge is sampled each cycle in *_WAIT. bus_enable deasserts in the cycle after acknowledge is seen.
- There is always ≥1 cycle with bus_enable=0 between transactions.
- Acknowledge seen outside *_WAIT is ignored.
- For responder latency L cycles (request to acknowledge):
  - one write = L+2 cycles;
  - one read = L+3 cycles;
  - total ≈ N(2L+5)+2.
- busy falls in the same cycle done rises.

## Configuration
- SRAM_BIST_TIMEOUT_EN defined:
  - A 10-bit watchdog counts cycles in *_WAIT.
  - After 1023 cycles without acknowledge, the block drops bus_enable, goes to DONE with pass=0 and error_count=16'hFFFF, and sets first_fail_addr to the stalled address.
- SRAM_BIST_TIMEOUT_EN undefined: the block waits for acknowledge indefinitely and the watchdog logic is absent.

## Structure
- Package sram_bist_pkg:
  - state enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE);
  - LFSR_ZERO_SUB = 16'hACE1;
  - timeout limit constant;
  - RW_READ / RW_WRITE encodings.
- Sub-module sram_bist_lfsr: inputs load, seed and step; output value. Handles zero-seed substitution.

## Test plan
- Zero-wait responder (L=1), base=0, count=4, seed=16'h0001: writes 0001, 0002, 0004, 0008 to byte addresses 0, 2, 4, 6; reads match; pass=1, error_count=0, ~30 cycles total.
- Responder corrupts the read at word 2 (XOR 16'h0100), count=8: error_count=1, first_fail_addr=base+2, pass=0.
- Wrap: base=18'h3FFFE, count=4: word addresses 3FFFE, 3FFFF, 00000, 00001; pass=1.
- count=0, and start pulsed while busy: done with pass=1 within 2 cycles and no bus_enable activity; a second start during a run has no effect.
- Reset asserted while bus_enable=1 in WR_WAIT, with a late acknowledge after release: all outputs 0, state IDLE, and the stray acknowledge is ignored.
- With SRAM_BIST_TIMEOUT_EN defined and a responder that never acknowledges: after 1023 cycles done=1, pass=0, error_count=16'hFFFF. Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM built-in self-test master.
// Optional watchdog: define SRAM_BIST_TIMEOUT_EN.
package sram_bist_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_WAIT,
      RD_REQ,
      RD_WAIT,
      CHECK,
      DONE
   } state_t;

   localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;
   localparam logic [9:0]  TIMEOUT_LIM   = 10'd1023;
   localparam logic        RW_READ       = 1'b1;
   localparam logic        RW_WRITE      = 1'b0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Bridge-style SRAM bus: request side driven by the BIST master.
// Optional watchdog in the master: SRAM_BIST_TIMEOUT_EN.
interface sram_bist_if #(
   parameter int ADDR_W = 19
);
   logic [ADDR_W-1:0] address;
   logic              bus_enable;
   logic [1:0]        byte_enable;
   logic              rw;
   logic [15:0]       write_data;
   logic              acknowledge;
   logic [15:0]       read_data;

   modport master (
      output address, bus_enable, byte_enable, rw, write_data,
      input  acknowledge, read_data
   );

   modport slave (
      input  address, bus_enable, byte_enable, rw, write_data,
      output acknowledge, read_data
   );
endinterface

// File: rtl/sram_bist_lfsr.sv
// 16-bit Fibonacci LFSR pattern source with zero-seed substitution.
// Used by sram_bist_master (macro SRAM_BIST_TIMEOUT_EN does not apply here).
module sram_bist_lfsr
   import sram_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= LFSR_ZERO_SUB;
      end else if (load) begin
         value <= (seed == '0) ? LFSR_ZERO_SUB : seed;
      end else if (step) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/sram_bist_master.sv
// SRAM self-test bus master: LFSR fill, read-back and compare.
// Define SRAM_BIST_TIMEOUT_EN to add a 10-bit acknowledge watchdog.
module sram_bist_master
   import sram_bist_pkg::*;
#(
   parameter int ADDR_W = 19
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        start,
   input  logic [17:0] base_addr,
   input  logic [17:0] word_count,
   input  logic [15:0] seed,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] error_count,
   output logic [17:0] first_fail_addr,
   sram_bist_if.master bus
);

   state_t            state, nxt;
   logic [17:0]       base_q, cnt_q, idx_q, waddr;
   logic [15:0]       seed_q, rd_q, lfsr, lfsr_seed;
   logic              lfsr_ld, lfsr_step;
   logic              start_ok, last, ack, wait_st, to;

   assign start_ok = start && (state == IDLE || state == DONE);
   assign waddr    = base_q + idx_q;
   assign last     = (idx_q == cnt_q - 18'd1);
   assign ack      = bus.acknowledge;
   assign wait_st  = (state == WR_WAIT) || (state == RD_WAIT);

   assign busy = !(state == IDLE || state == DONE);
   assign done = (state == DONE);
   assign pass = done && (error_count == '0);

`ifdef SRAM_BIST_TIMEOUT_EN
   logic [9:0] wd_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wd_q <= '0;
      end else if (!wait_st) begin
         wd_q <= '0;
      end else if (!ack) begin
         wd_q <= wd_q + 10'd1;
      end
   end

   assign to = wait_st && !ack && (wd_q == TIMEOUT_LIM);
`else
   assign to = 1'b0;
`endif

   sram_bist_lfsr u_lfsr (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .load  (lfsr_ld),
      .step  (lfsr_step),
      .seed  (lfsr_seed),
      .value (lfsr)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt       = state;
      lfsr_ld   = 1'b0;
      lfsr_step = 1'b0;
      lfsr_seed = seed_q;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               lfsr_ld   = 1'b1;
               lfsr_seed = seed;
               nxt       = (word_count == '0) ? DONE : WR_REQ;
            end
         end
         WR_REQ: nxt = WR_WAIT;
         WR_WAIT: begin
            if (ack) begin
               lfsr_step = 1'b1;
               lfsr_ld   = last;
               nxt       = last ? RD_REQ : WR_REQ;
            end else if (to) begin
               nxt = DONE;
            end
         end
         RD_REQ: nxt = RD_WAIT;
         RD_WAIT: begin
            if (ack) begin
               nxt = CHECK;
            end else if (to) begin
               nxt = DONE;
            end
         end
         CHECK: begin
            lfsr_step = 1'b1;
            nxt       = last ? DONE : RD_REQ;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         base_q          <= '0;
         cnt_q           <= '0;
         idx_q           <= '0;
         seed_q          <= '0;
         rd_q            <= '0;
         error_count     <= '0;
         first_fail_addr <= '0;
         bus.bus_enable  <= 1'b0;
         bus.byte_enable <= 2'b00;
         bus.address     <= '0;
         bus.rw          <= 1'b0;
         bus.write_data  <= '0;
      end else begin
         if (start_ok) begin
            base_q          <= base_addr;
            cnt_q           <= word_count;
            seed_q          <= seed;
            idx_q           <= '0;
            error_count     <= '0;
            first_fail_addr <= '0;
         end
         if (state == WR_REQ || state == RD_REQ) begin
            bus.bus_enable  <= 1'b1;
            bus.byte_enable <= 2'b11;
            bus.address     <= ADDR_W'({waddr, 1'b0});
            bus.rw          <= (state == RD_REQ) ? RW_READ : RW_WRITE;
         end
         if (state == WR_REQ) begin
            bus.write_data <= lfsr;
         end
         if (wait_st && (ack || to)) begin
            bus.bus_enable <= 1'b0;
         end
         if (state == WR_WAIT && ack) begin
            idx_q <= last ? '0 : idx_q + 18'd1;
         end
         if (state == RD_WAIT && ack) begin
            rd_q <= bus.read_data;
         end
         if (state == CHECK) begin
            idx_q <= idx_q + 18'd1;
            if (rd_q != lfsr) begin
               if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
               if (error_count == '0) first_fail_addr <= waddr;
            end
         end
         // A stalled request reports as a saturated failure at its address
         if (to) begin
            error_count     <= 16'hFFFF;
            first_fail_addr <= waddr;
         end
      end
   end

endmodule

// File: tb/tb_sram_bist_master.sv
// Scoreboard bench for sram_bist_master with a one-cycle SRAM responder.
// Build with SRAM_BIST_TIMEOUT_EN to exercise the watchdog path.
module tb_sram_bist_master;

   typedef struct packed {
      logic        rw;
      logic [18:0] addr;
      logic [15:0] data;
   } txn_t;

   typedef struct packed {
      logic        pass;
      logic [15:0] err;
      logic [17:0] ffa;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [17:0] base_addr = '0;
   logic [17:0] word_count = '0;
   logic [15:0] seed = '0;
   logic        busy, done, pass;
   logic [15:0] error_count;
   logic [17:0] first_fail_addr;

   logic        resp_en = 1'b1;
   logic        stray = 1'b0;
   logic        corrupt_en = 1'b0;
   logic [17:0] corrupt_wa = '0;
   logic        ack_r = 1'b0;
   logic [15:0] rd_r = '0;
   logic [17:0] rwa;
   logic [15:0] mem [0:262143];

   txn_t        txq[$];
   res_t        resq[$];
   logic [15:0] dv [8];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        be_prev = 1'b0;
   logic        done_prev = 1'b0;

   sram_bist_if #(.ADDR_W(19)) bus ();

   sram_bist_master #(.ADDR_W(19)) dut (
      .clk_clk         (clk),
      .reset_reset_n   (rst_n),
      .start           (start),
      .base_addr       (base_addr),
      .word_count      (word_count),
      .seed            (seed),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .error_count     (error_count),
      .first_fail_addr (first_fail_addr),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   assign bus.acknowledge = ack_r | stray;
   assign bus.read_data   = rd_r;
   assign rwa             = bus.address[18:1];

   // Responder: acknowledges one cycle after it sees a request
   always @(posedge clk) begin
      ack_r <= 1'b0;
      if (resp_en && bus.bus_enable && !ack_r) begin
         ack_r <= 1'b1;
         if (!bus.rw) mem[rwa] <= bus.write_data;
         else rd_r <= mem[rwa] ^ ((corrupt_en && rwa == corrupt_wa) ? 16'h0100 : 16'h0000);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected bus transactions and completion results
   always @(negedge clk) begin
      txn_t t;
      res_t r;
      if (bus.bus_enable && !be_prev) begin
         if (txq.size() == 0) begin
            chk("unexpected_txn", {13'd0, bus.address}, 32'hFFFF_FFFF);
         end else begin
            t = txq.pop_front();
            chk("txn_rw", {31'd0, bus.rw}, {31'd0, t.rw});
            chk("txn_addr", {13'd0, bus.address}, {13'd0, t.addr});
            chk("txn_be", {30'd0, bus.byte_enable}, 32'd3);
            if (!t.rw) chk("txn_wdata", {16'd0, bus.write_data}, {16'd0, t.data});
         end
      end
      if (done && !done_prev) begin
         if (resq.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            r = resq.pop_front();
            chk("res_pass", {31'd0, pass}, {31'd0, r.pass});
            chk("res_err", {16'd0, error_count}, {16'd0, r.err});
            chk("res_ffa", {14'd0, first_fail_addr}, {14'd0, r.ffa});
         end
      end
      be_prev   = bus.bus_enable;
      done_prev = done;
   end

   task automatic push_run(input logic [17:0] b, input int n);
      logic [17:0] wa;
      for (int i = 0; i < n; i++) begin
         wa = b + 18'(i);
         txq.push_back('{rw: 1'b0, addr: {wa, 1'b0}, data: dv[i]});
      end
      for (int i = 0; i < n; i++) begin
         wa = b + 18'(i);
         txq.push_back('{rw: 1'b1, addr: {wa, 1'b0}, data: 16'h0000});
      end
   endtask

   task automatic go(input logic [17:0] b, input logic [17:0] n, input logic [15:0] s);
      @(negedge clk);
      base_addr  = b;
      word_count = n;
      seed       = s;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_be", {31'd0, bus.bus_enable}, 32'd0);
      chk("rst_addr", {13'd0, bus.address}, 32'd0);
      rst_n = 1'b1;

      // Basic fill and check, seed 1
      dv = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 0, 0, 0, 0};
      push_run(18'h0, 4);
      resq.push_back('{pass: 1'b1, err: 16'h0, ffa: 18'h0});
      go(18'h0, 18'd4, 16'h0001);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      wait_done(200, n);
      chk("t1_cycles", n, 32'd28);
      chk("t1_busy_end", {31'd0, busy}, 32'd0);

      // Corrupted read at word 2, plus ignored start mid-run
      dv = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
             16'h0010, 16'h0020, 16'h0040, 16'h0080};
      push_run(18'h10, 8);
      resq.push_back('{pass: 1'b0, err: 16'h1, ffa: 18'h12});
      corrupt_en = 1'b1;
      corrupt_wa = 18'h12;
      go(18'h10, 18'd8, 16'h0001);
      repeat (10) @(negedge clk);
      go(18'h100, 18'd1, 16'h5555);
      wait_done(300, n);
      corrupt_en = 1'b0;

      // Address wrap with zero seed
      dv = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F, 0, 0, 0, 0};
      push_run(18'h3FFFE, 4);
      resq.push_back('{pass: 1'b1, err: 16'h0, ffa: 18'h0});
      go(18'h3FFFE, 18'd4, 16'h0000);
      wait_done(200, n);

      // Zero-length run from idle
      do_reset();
      resq.push_back('{pass: 1'b1, err: 16'h0, ffa: 18'h0});
      go(18'h55, 18'd0, 16'h1234);
      wait_done(10, n);
      chk("t4_fast", {31'd0, n <= 2}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);

      // Reset during an outstanding write, then a stray acknowledge
      resp_en = 1'b0;
      txq.push_back('{rw: 1'b0, addr: 19'h40, data: 16'h0001});
      go(18'h20, 18'd4, 16'h0001);
      repeat (4) @(negedge clk);
      chk("t5_be_before", {31'd0, bus.bus_enable}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_be_async", {31'd0, bus.bus_enable}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_addr", {13'd0, bus.address}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_be_after", {31'd0, bus.bus_enable}, 32'd0);
      chk("t5_busy_after", {31'd0, busy}, 32'd0);
      chk("t5_done_after", {31'd0, done}, 32'd0);
      chk("t5_err_after", {16'd0, error_count}, 32'd0);

      // Responder that never acknowledges
      txq.push_back('{rw: 1'b0, addr: 19'hA0, data: 16'h0001});
`ifdef SRAM_BIST_TIMEOUT_EN
      resq.push_back('{pass: 1'b0, err: 16'hFFFF, ffa: 18'h50});
      go(18'h50, 18'd2, 16'h0001);
      wait_done(1200, n);
      chk("t6_be", {31'd0, bus.bus_enable}, 32'd0);
`else
      go(18'h50, 18'd2, 16'h0001);
      repeat (1100) @(negedge clk);
      chk("t6_busy", {31'd0, busy}, 32'd1);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_be", {31'd0, bus.bus_enable}, 32'd1);
`endif
      do_reset();
      resp_en = 1'b1;
      repeat (2) @(negedge clk);

      chk("txq_empty", txq.size(), 32'd0);
      chk("resq_empty", resq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
